// File: rtl/fxp_pkg.sv
// Shared Q8.8 fixed-point definitions for the bias-gradient datapath.
package fxp_pkg;

    localparam int unsigned FXP_W    = 16;
    localparam int unsigned FXP_FRAC = 8;

    typedef logic signed [FXP_W-1:0] fxp_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_SCALE  = 2'd2,
        S_UPDATE = 2'd3
    } bias_grad_state_t;

    // Clamp a sign-extended wide value into the 16-bit signed range.
    function automatic fxp_t sat16(input logic signed [63:0] v);
        fxp_t r;
        if (v > 64'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -64'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = fxp_t'(v[15:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/fxp_sat.sv
// Combinational wide-to-16-bit signed saturator (IN_W must be at least 17).
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int unsigned IN_W = 17
) (
    input  logic signed [IN_W-1:0] din_i,
    output fxp_t                   dout_c
);

    // Bits 15 and above must all equal the sign for the value to fit.
    logic [IN_W-16:0] top_bits;
    assign top_bits = din_i[IN_W-1:15];

    // Pass through when representable, otherwise clamp toward the sign.
    always_comb begin
        dout_c = fxp_t'(din_i[15:0]);
        if (!((&top_bits) || !(|top_bits))) begin
            dout_c = din_i[IN_W-1] ? 16'sh8000 : 16'sh7FFF;
        end
    end

endmodule

// File: rtl/bias_grad.sv
// Reduces a column's output gradients to dL/db and emits the SGD-updated bias.
module bias_grad
    import fxp_pkg::*;
#(
    parameter int unsigned BATCH_W = 8,
    parameter int unsigned FRAC    = FXP_FRAC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic [BATCH_W-1:0] batch_size_in,
    input  logic [15:0]        lr_in,
    input  logic [15:0]        bias_in,
    input  logic               grad_valid_in,
    input  logic [15:0]        grad_data_in,
    output logic [15:0]        bias_data_out,
    output logic [15:0]        grad_sum_out,
    output logic               bias_valid_out,
    output logic               busy_out
);

    localparam int unsigned ACC_W  = FXP_W + BATCH_W;
    localparam int unsigned PROD_W = ACC_W + FXP_W;

    bias_grad_state_t           state_q, state_d;
    logic [BATCH_W-1:0]         batch_q, batch_d;
    logic [BATCH_W-1:0]         count_q, count_d;
    fxp_t                       lr_q, lr_d;
    fxp_t                       bias_q, bias_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    fxp_t                       bias_out_q, bias_out_d;
    fxp_t                       gsum_q, gsum_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;

    logic signed [PROD_W-1:0]   shifted_c;
    fxp_t                       step_c;
    logic signed [16:0]         diff_c;
    fxp_t                       new_bias_c;

    // Scaled step, floored by the arithmetic shift, then clamped.
    assign shifted_c = prod_q >>> FRAC;

    fxp_sat #(.IN_W(PROD_W)) u_sat_step (
        .din_i  (shifted_c),
        .dout_c (step_c)
    );

    // Bias minus step at 17 bits cannot wrap; saturate back to 16.
    assign diff_c = 17'(bias_q) - 17'(step_c);

    fxp_sat #(.IN_W(17)) u_sat_bias (
        .din_i  (diff_c),
        .dout_c (new_bias_c)
    );

    // Next-state and datapath updates for the reduction sequence.
    always_comb begin
        state_d    = state_q;
        batch_d    = batch_q;
        count_d    = count_q;
        lr_d       = lr_q;
        bias_d     = bias_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        bias_out_d = '0;
        gsum_d     = '0;
        valid_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_in && (batch_size_in != '0)) begin
                    batch_d = batch_size_in;
                    lr_d    = fxp_t'(lr_in);
                    bias_d  = fxp_t'(bias_in);
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (grad_valid_in) begin
                    acc_d   = acc_q + ACC_W'($signed(grad_data_in));
                    count_d = count_q + BATCH_W'(1);
                    if (count_d == batch_q) begin
                        state_d = S_SCALE;
                    end
                end
            end
            S_SCALE: begin
                prod_d  = PROD_W'(acc_q) * PROD_W'(lr_q);
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                bias_out_d = new_bias_c;
                gsum_d     = sat16(64'(acc_q));
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Busy stays up through the cycle the result is presented.
        busy_d = (state_d != S_IDLE) || (state_q == S_UPDATE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            batch_q    <= '0;
            count_q    <= '0;
            lr_q       <= '0;
            bias_q     <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            bias_out_q <= '0;
            gsum_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            batch_q    <= batch_d;
            count_q    <= count_d;
            lr_q       <= lr_d;
            bias_q     <= bias_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            bias_out_q <= bias_out_d;
            gsum_q     <= gsum_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bias_data_out  = bias_out_q;
    assign grad_sum_out   = gsum_q;
    assign bias_valid_out = valid_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_bias_grad.sv
// Scoreboard bench for bias_grad: driver pushes expected results, monitor checks them.
module tb_bias_grad;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic [7:0]  batch_size_in;
    logic [15:0] lr_in;
    logic [15:0] bias_in;
    logic        grad_valid_in;
    logic [15:0] grad_data_in;
    logic [15:0] bias_data_out;
    logic [15:0] grad_sum_out;
    logic        bias_valid_out;
    logic        busy_out;

    bias_grad #(.BATCH_W(8), .FRAC(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_in       (start_in),
        .batch_size_in  (batch_size_in),
        .lr_in          (lr_in),
        .bias_in        (bias_in),
        .grad_valid_in  (grad_valid_in),
        .grad_data_in   (grad_data_in),
        .bias_data_out  (bias_data_out),
        .grad_sum_out   (grad_sum_out),
        .bias_valid_out (bias_valid_out),
        .busy_out       (busy_out)
    );

    typedef struct {
        logic [15:0] bias;
        logic [15:0] sum;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] gq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clamp an integer into the signed 16-bit range.
    function automatic logic [15:0] clamp16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    // Reference: sum grads, multiply by lr, floor-divide by 256, subtract from bias.
    task automatic model(input logic [15:0] lr, input logic [15:0] bias,
                         output logic [15:0] eb, output logic [15:0] es);
        longint s = 0;
        longint p, q;
        logic [15:0] st;
        foreach (gq[i]) s += longint'($signed(gq[i]));
        p = s * longint'($signed(lr));
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        st = clamp16(q);
        eb = clamp16(longint'($signed(bias)) - longint'($signed(st)));
        es = clamp16(s);
    endtask

    // Monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bias_valid_out) begin
                if (prev_valid) begin
                    checks++; errors++;
                    $display("FAIL valid_width: valid high on two consecutive cycles at t=%0t", $time);
                end
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: result 0x%0h with empty scoreboard at t=%0t",
                             bias_data_out, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bias_data", 32'(bias_data_out), 32'(e.bias));
                    chk("grad_sum",  32'(grad_sum_out),  32'(e.sum));
                    chk("latency",   32'(cyc),           32'(e.cyc));
                end
            end else begin
                chk("idle_bias_zero", 32'(bias_data_out), 32'd0);
                chk("idle_sum_zero",  32'(grad_sum_out),  32'd0);
            end
        end
        prev_valid = rst ? 1'b0 : bias_valid_out;
    end

    task automatic wait_idle();
        int k = 0;
        while (busy_out && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy_out) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy_out=%0b after %0d cycles", busy_out, k);
        end
    endtask

    // Issue one reduction over gq; extra adds a spurious start and post-batch grads.
    task automatic run_batch(input logic [15:0] lr, input logic [15:0] bias,
                             input int stall, input bit rnd_stall, input bit extra,
                             input bit use_model, input logic [15:0] eb, input logic [15:0] es);
        exp_t e;
        logic [15:0] mb, ms;
        wait_idle();
        start_in      = 1'b1;
        batch_size_in = 8'(gq.size());
        lr_in         = lr;
        bias_in       = bias;
        @(negedge clk);
        start_in      = 1'b0;
        lr_in         = 16'($urandom);
        bias_in       = 16'($urandom);
        batch_size_in = 8'($urandom);
        chk("busy_on_start", 32'(busy_out), 32'd1);
        for (int i = 0; i < gq.size(); i++) begin
            int st;
            st = rnd_stall ? int'($urandom_range(0, 2)) : stall;
            if (i == 0) st = 0;
            repeat (st) begin
                grad_valid_in = 1'b0;
                grad_data_in  = 16'($urandom);
                @(negedge clk);
            end
            grad_valid_in = 1'b1;
            grad_data_in  = gq[i];
            if (extra && i == 0) begin
                start_in      = 1'b1;
                batch_size_in = 8'd1;
                lr_in         = 16'h7FFF;
                bias_in       = 16'h1234;
            end
            @(negedge clk);
            start_in = 1'b0;
        end
        if (use_model) begin
            model(lr, bias, mb, ms);
            e.bias = mb; e.sum = ms;
        end else begin
            e.bias = eb; e.sum = es;
        end
        e.cyc = cyc + 2;
        sb.push_back(e);
        if (extra) begin
            repeat (2) begin
                grad_valid_in = 1'b1;
                grad_data_in  = 16'h4000;
                @(negedge clk);
            end
        end
        grad_valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; batch_size_in = '0; lr_in = '0; bias_in = '0;
        grad_valid_in = 1'b0; grad_data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bias",  32'(bias_data_out),  32'd0);
        chk("rst_sum",   32'(grad_sum_out),   32'd0);
        chk("rst_valid", 32'(bias_valid_out), 32'd0);
        chk("rst_busy",  32'(busy_out),       32'd0);

        // Basic and stalled variants of the same reduction.
        gq = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run_batch(16'h0080, 16'h0300, 0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0400);
        run_batch(16'h0080, 16'h0300, 3, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0400);

        // Saturation low: large positive sum drives bias to the negative rail.
        gq.delete();
        repeat (255) gq.push_back(16'h7FFF);
        run_batch(16'h0100, 16'h8000, 0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h7FFF);

        // Saturation high: negative step pushes bias past the positive rail.
        gq = '{16'hFF00, 16'hFF00};
        run_batch(16'h0100, 16'h7F00, 0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'hFE00);

        // Zero-size start is ignored.
        wait_idle();
        start_in = 1'b1; batch_size_in = 8'd0; lr_in = 16'h0100; bias_in = 16'h0100;
        @(negedge clk);
        start_in = 1'b0;
        chk("zero_batch_busy", 32'(busy_out), 32'd0);
        @(negedge clk);
        chk("zero_batch_busy2", 32'(busy_out), 32'd0);

        // Spurious start in ACCUM and grads in SCALE/UPDATE leave the result alone.
        gq = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run_batch(16'h0080, 16'h0300, 1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0400);

        // Reset partway through a batch; no result may appear for it.
        wait_idle();
        start_in = 1'b1; batch_size_in = 8'd4; lr_in = 16'h0100; bias_in = 16'h0100;
        @(negedge clk);
        start_in = 1'b0;
        repeat (2) begin
            grad_valid_in = 1'b1; grad_data_in = 16'h0300;
            @(negedge clk);
        end
        grad_valid_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",  32'(busy_out),       32'd0);
        chk("midrst_valid", 32'(bias_valid_out), 32'd0);
        chk("midrst_bias",  32'(bias_data_out),  32'd0);
        repeat (6) @(negedge clk);
        chk("midrst_still_idle", 32'(busy_out), 32'd0);
        gq = '{16'h0200};
        run_batch(16'h0100, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'hFE00, 16'h0200);

        // Randomized batches against the arithmetic reference.
        for (int n = 0; n < 25; n++) begin
            int sz;
            logic [15:0] lr, bias;
            sz = int'($urandom_range(1, 12));
            gq.delete();
            for (int j = 0; j < sz; j++) begin
                if ($urandom_range(0, 3) == 0) gq.push_back(16'($urandom));
                else gq.push_back(16'($signed(12'($urandom))));
            end
            lr   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0200));
            bias = 16'($urandom);
            run_batch(lr, bias, 0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 16'h0, 16'h0);
        end

        begin
            int k = 0;
            while (sb.size() != 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (sb.size() != 0) begin
                checks++; errors++;
                $display("FAIL drain_timeout: %0d results never arrived", sb.size());
            end
        end
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
